// File: rtl/reg_alu_seq.sv
// Command sequencer: replays a small command memory onto a register-ALU
// command bus, one command per cycle, with load, start, abort and done handshake.
`timescale 1ns/1ps
module reg_alu_seq #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3,
  parameter int unsigned DW    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic [AW-1:0]     load_addr,
  input  logic [13+DW-1:0]  load_data,
  input  logic [AW:0]       prog_len,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [AW:0]       pc,
  output logic              sel,
  output logic              wr,
  output logic [1:0]        op,
  output logic [2:0]        rd_addr_a,
  output logic [2:0]        rd_addr_b,
  output logic [2:0]        wr_addr,
  output logic [DW-1:0]     d_in
);

  localparam int unsigned CW = 13 + DW;
  localparam int unsigned LW = AW + 1;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t        state;
  logic [CW-1:0] mem [DEPTH];
  logic [CW-1:0] cmd_q;
  logic [LW-1:0] eff_len;

  // Lengths above the memory size replay the whole memory once.
  assign eff_len = (prog_len > LW'(DEPTH)) ? LW'(DEPTH) : prog_len;

  assign {sel, wr, op, rd_addr_a, rd_addr_b, wr_addr, d_in} = cmd_q;

  // Command memory: writable only while idle, cleared by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (state == IDLE && load_en) begin
      mem[load_addr] <= load_data;
    end
  end

  // Sequencer FSM; bus, pc, busy and done are all registered here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pc    <= '0;
      cmd_q <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !load_en) begin
            if (eff_len != '0) begin
              cmd_q <= mem[AW'(0)];
              pc    <= LW'(1);
              busy  <= 1'b1;
              state <= RUN;
            end else begin
              done  <= 1'b1;
              state <= FIN;
            end
          end
        end
        RUN: begin
          if (abort) begin
            cmd_q <= '0;
            pc    <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (pc < eff_len) begin
            cmd_q <= mem[pc[AW-1:0]];
            pc    <= pc + LW'(1);
          end else begin
            // A prog_len lowered below pc mid-run also ends the run here.
            cmd_q <= '0;
            pc    <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FIN;
          end
        end
        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          cmd_q <= '0;
          pc    <= '0;
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
